// File: rtl/store_buffer.sv
// Store buffer: formats sw/sh/sb into word-aligned byte-enabled writes, queues them and drains over req/ack.
// Optional STORE_MERGE_EN lets a store coalesce into the most recently queued entry.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     st_valid,
  input  logic [5:0]               st_op,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  output logic                     st_ready,
  input  logic                     ld_check,
  input  logic [31:0]              ld_addr,
  output logic                     ld_hazard,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_be,
  input  logic                     mem_ack,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_misalign
);
  // state | meaning
  // IDLE  | no write presented to memory
  // REQ   | head entry presented, waiting for mem_ack
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [31:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [3:0]    be_q   [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0] head, tail;
  logic [0:0]    state;

  logic        op_sw, op_sh, op_sb, is_store, misalign, push_req;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_data;
  logic        full, merge_hit, do_alloc, do_pop;
  logic        unused_ld_lsb;

  always_comb begin
    op_sw    = (st_op == 6'b101011);
    op_sh    = (st_op == 6'b101001);
    op_sb    = (st_op == 6'b101000);
    is_store = op_sw | op_sh | op_sb;
    fmt_be   = 4'b0000;
    fmt_data = 32'h0;
    misalign = 1'b0;
    if (op_sw) begin
      fmt_be   = 4'b1111;
      fmt_data = st_data;
      misalign = (st_addr[1:0] != 2'b00);
    end else if (op_sh) begin
      fmt_be   = st_addr[1] ? 4'b1100 : 4'b0011;
      fmt_data = {st_data[15:0], st_data[15:0]};
      misalign = st_addr[0];
    end else if (op_sb) begin
      fmt_be   = 4'b0001 << st_addr[1:0];
      fmt_data = {4{st_data[7:0]}};
    end
  end

  assign push_req = st_valid && is_store && !misalign;
  assign full     = (count == DEPTH_C);

`ifdef STORE_MERGE_EN
  logic [PW-1:0] last;
  assign last = tail - PW'(1);
  // The entry being presented to memory must not change under the handshake.
  assign merge_hit = push_req && vld_q[last]
                     && (addr_q[last][31:2] == st_addr[31:2])
                     && !((state == S_REQ) && (last == head));
`else
  assign merge_hit = 1'b0;
`endif

  assign st_ready = !full || merge_hit;
  assign do_alloc = push_req && !merge_hit && !full;
  assign do_pop   = (state == S_REQ) && mem_ack;

  assign mem_req   = (state == S_REQ);
  assign mem_addr  = addr_q[head];
  assign mem_wdata = data_q[head];
  assign mem_be    = be_q[head];

  always_comb begin
    ld_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (addr_q[i][31:2] == ld_addr[31:2])) ld_hazard = 1'b1;
    end
    ld_hazard = ld_hazard & ld_check;
  end
  assign unused_ld_lsb = ^ld_addr[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        be_q[i]   <= '0;
      end
      vld_q <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      if (do_alloc) begin
        addr_q[tail] <= {st_addr[31:2], 2'b00};
        data_q[tail] <= fmt_data;
        be_q[tail]   <= fmt_be;
        vld_q[tail]  <= 1'b1;
        tail         <= tail + PW'(1);
      end
`ifdef STORE_MERGE_EN
      if (merge_hit) begin
        for (int b = 0; b < 4; b++) begin
          if (fmt_be[b]) data_q[last][8*b +: 8] <= fmt_data[8*b +: 8];
        end
        be_q[last] <= be_q[last] | fmt_be;
      end
`endif
      if (do_pop) begin
        vld_q[head] <= 1'b0;
        head        <= head + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count        <= '0;
      state        <= S_IDLE;
      err_misalign <= 1'b0;
    end else begin
      err_misalign <= st_valid && is_store && misalign;
      case ({do_alloc, do_pop})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
      case (state)
        S_IDLE:  if (count != '0) state <= S_REQ;
        S_REQ:   if (mem_ack && (count <= ONE_C)) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
